data_ram_arbiter: RTL and testbench

//   Shares the single-port data RAM between two requesters: port 0 (MEM stage

---
 rtl/data_ram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_data_ram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// Two-port arbiter in front of a single-port data RAM: grants one requester,
// drives one RAM access cycle, then returns read data and a one-cycle ack.
module data_ram_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q;
  logic                win_q;
  logic                last_q;
  logic                m0_ack_q;
  logic                m1_ack_q;
  logic [DATA_W-1:0]   m0_rdata_q;
  logic [DATA_W-1:0]   m1_rdata_q;
  logic                ram_ce_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [3:0]          ram_sel_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic                busy_q;

  logic                grant_d;
  logic                cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_d;
  logic [3:0]          cmd_sel_d;
  logic [DATA_W-1:0]   cmd_wdata_d;

  // Winner selection; on contention the port not granted last wins in round-robin mode.
  always_comb begin
    grant_d = 1'b0;
    if (m0_req_i && m1_req_i) begin
      if (ROUND_ROBIN) begin
        grant_d = ~last_q;
      end else begin
        grant_d = 1'b0;
      end
    end else if (m1_req_i) begin
      grant_d = 1'b1;
    end else begin
      grant_d = 1'b0;
    end
    if (grant_d) begin
      cmd_we_d    = m1_we_i;
      cmd_addr_d  = m1_addr_i;
      cmd_sel_d   = m1_sel_i;
      cmd_wdata_d = m1_wdata_i;
    end else begin
      cmd_we_d    = m0_we_i;
      cmd_addr_d  = m0_addr_i;
      cmd_sel_d   = m0_sel_i;
      cmd_wdata_d = m0_wdata_i;
    end
  end

  // Handshake FSM with all outputs registered; RAM command registers hold while idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      last_q      <= 1'b1;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_sel_q   <= 4'b0000;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          if (m0_req_i || m1_req_i) begin
            win_q       <= grant_d;
            last_q      <= grant_d;
            ram_ce_q    <= 1'b1;
            ram_we_q    <= cmd_we_d;
            ram_addr_q  <= cmd_addr_d;
            ram_sel_q   <= cmd_sel_d;
            ram_wdata_q <= cmd_wdata_d;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          // Only the winner's read-data register moves, and only for loads.
          if (!ram_we_q) begin
            if (win_q) begin
              m1_rdata_q <= ram_rdata_i;
            end else begin
              m0_rdata_q <= ram_rdata_i;
            end
          end
          ram_ce_q <= 1'b0;
          ram_we_q <= 1'b0;
          m0_ack_q <= ~win_q;
          m1_ack_q <= win_q;
          state_q  <= RESP;
        end
        RESP: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          ram_ce_q <= 1'b0;
          ram_we_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign m0_ack_o    = m0_ack_q;
  assign m1_ack_o    = m1_ack_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign ram_ce_o    = ram_ce_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_sel_o   = ram_sel_q;
  assign ram_wdata_o = ram_wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: a transaction-level model checked every cycle,
// plus directed transactions with hand-computed expectations.
module tb_data_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0, m1_addr = 32'h0, m1_wdata = 32'h0;
  logic [3:0]  m0_sel = 4'h0, m1_sel = 4'h0;
  logic        m0_ack, m1_ack, ram_ce, ram_we, busy;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  // second instance, fixed priority, with its own inputs
  logic        n0_req = 1'b0, n1_req = 1'b0;
  logic        n0_ack, n1_ack, n_ce, n_we, n_busy;
  logic [31:0] n0_rdata, n1_rdata, n_addr, n_wdata;
  logic [31:0] n_rdata = 32'h5A5A0001;
  logic [3:0]  n_sel;

  data_ram_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_sel_i(m0_sel),
    .m0_wdata_i(m0_wdata), .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_sel_i(m1_sel),
    .m1_wdata_i(m1_wdata), .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_sel_o(ram_sel),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .busy_o(busy)
  );

  data_ram_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(n0_req), .m0_we_i(1'b0), .m0_addr_i(32'h0), .m0_sel_i(4'hF),
    .m0_wdata_i(32'h0), .m0_ack_o(n0_ack), .m0_rdata_o(n0_rdata),
    .m1_req_i(n1_req), .m1_we_i(1'b0), .m1_addr_i(32'h4), .m1_sel_i(4'hF),
    .m1_wdata_i(32'h0), .m1_ack_o(n1_ack), .m1_rdata_o(n1_rdata),
    .ram_ce_o(n_ce), .ram_we_o(n_we), .ram_addr_o(n_addr), .ram_sel_o(n_sel),
    .ram_wdata_o(n_wdata), .ram_rdata_i(n_rdata), .busy_o(n_busy)
  );

  // RAM behind the DUT: no reset, byte-lane writes, combinational read
  logic [31:0] mem [256];
  assign ram_rdata = mem[ram_addr[9:2]];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state: what the arbiter must present, by transaction
  logic [31:0] ref_mem [256];
  int          m_phase = 0;        // 0 free, 1 access cycle, 2 response cycle
  logic        m_win = 1'b0, m_last = 1'b1, m_we = 1'b0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
  logic [3:0]  m_sel = 4'h0;
  logic [1:0]  e_ack = 2'b00;
  logic [31:0] e_rd0 = 32'h0, e_rd1 = 32'h0;
  logic        e_ce = 1'b0, e_we = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
  end

  initial forever begin
    @(posedge clk);
    if (ram_ce && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] = ram_wdata[8*b +: 8];
  end

  initial forever begin
    @(posedge clk);
    if (m_phase == 1) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_sel[b]) ref_mem[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
      end else if (rst_n) begin
        if (m_win) e_rd1 = ref_mem[m_addr[9:2]];
        else e_rd0 = ref_mem[m_addr[9:2]];
      end
    end
    if (!rst_n) begin
      m_phase = 0; m_last = 1'b1; e_ack = 2'b00; e_rd0 = 32'h0; e_rd1 = 32'h0;
      e_ce = 1'b0; e_we = 1'b0; m_addr = 32'h0; m_sel = 4'h0; m_wdata = 32'h0;
    end else begin
      e_ack = 2'b00;
      if (m_phase == 0) begin
        if (m0_req || m1_req) begin
          m_win = (m0_req && m1_req) ? !m_last : m1_req;
          m_last = m_win;
          m_we    = m_win ? m1_we : m0_we;
          m_addr  = m_win ? m1_addr : m0_addr;
          m_sel   = m_win ? m1_sel : m0_sel;
          m_wdata = m_win ? m1_wdata : m0_wdata;
          e_ce = 1'b1; e_we = m_we; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        e_ack[m_win] = 1'b1; e_ce = 1'b0; e_we = 1'b0; m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("m_ack0", m0_ack, e_ack[0]);
    chk("m_ack1", m1_ack, e_ack[1]);
    chk("m_rdata0", m0_rdata, e_rd0);
    chk("m_rdata1", m1_rdata, e_rd1);
    chk("m_busy", busy, m_phase != 0);
    chk("m_ce", ram_ce, e_ce);
    chk("m_we", ram_we, e_we);
    chk("m_addr", ram_addr, m_addr);
    chk("m_sel", ram_sel, m_sel);
    chk("m_wdata", ram_wdata, m_wdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input bit req, input bit we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wd);
    if (p) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_sel = sel; m1_wdata = wd;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_sel = sel; m0_wdata = wd;
    end
  endtask

  // one full transaction starting in an idle cycle; ends in the idle cycle after ack
  task automatic xact(input bit p, input bit we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] wd, output logic [31:0] rd);
    drive(p, 1'b1, we, addr, sel, wd);
    tick();
    @(negedge clk);
    chk("acc_ce", ram_ce, 32'd1);
    chk("acc_we", ram_we, we);
    chk("acc_addr", ram_addr, addr);
    tick();
    @(negedge clk);
    chk("ack_winner", p ? m1_ack : m0_ack, 32'd1);
    chk("ack_other", p ? m0_ack : m1_ack, 32'd0);
    chk("resp_ce", ram_ce, 32'd0);
    rd = p ? m1_rdata : m0_rdata;
    tick();
    drive(p, 1'b0, we, addr, sel, wd);
  endtask

  logic [31:0] rd;
  int c;

  initial begin
    tick(); tick(); tick();
    @(negedge clk);
    chk("rst_busy", busy, 32'd0);
    chk("rst_ce", ram_ce, 32'd0);
    chk("rst_rdata0", m0_rdata, 32'h0);
    chk("rst_addr", ram_addr, 32'h0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("idle_ce", ram_ce, 32'd0);
      chk("idle_busy", busy, 32'd0);
      chk("idle_acks", {m1_ack, m0_ack}, 32'd0);
    end
    tick();

    xact(1'b0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, rd);
    chk("m1_ack_quiet", m1_ack, 32'd0);
    xact(1'b0, 1'b0, 32'h10, 4'b1111, 32'h0, rd);
    chk("load_full", rd, 32'hDEADBEEF);
    xact(1'b0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, rd);
    xact(1'b0, 1'b0, 32'h10, 4'b0010, 32'h0, rd);
    chk("load_partial", rd, 32'hDEADAAEF);

    // command change after latch must not reach the RAM
    drive(1'b0, 1'b1, 1'b1, 32'h30, 4'hF, 32'hA5A5A5A5);
    tick();
    m0_addr = 32'h34; m0_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("hold_addr", ram_addr, 32'h30);
    chk("hold_wdata", ram_wdata, 32'hA5A5A5A5);
    tick();
    @(negedge clk);
    chk("hold_ack", m0_ack, 32'd1);
    tick();
    m0_req = 1'b0;
    xact(1'b0, 1'b0, 32'h30, 4'hF, 32'h0, rd);
    chk("hold_load30", rd, 32'hA5A5A5A5);
    xact(1'b0, 1'b0, 32'h34, 4'hF, 32'h0, rd);
    chk("hold_load34", rd, 32'h0);

    xact(1'b1, 1'b1, 32'h44, 4'b1001, 32'h11223344, rd);
    xact(1'b1, 1'b0, 32'h44, 4'hF, 32'h0, rd);
    chk("m1_load", rd, 32'h11000044);
    chk("m0_rdata_kept", m0_rdata, 32'h0);

    // reset during the access cycle of an m1 load
    drive(1'b1, 1'b1, 1'b0, 32'h44, 4'hF, 32'h0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; m1_req = 1'b0;
    @(negedge clk);
    chk("rstacc_ack", m1_ack, 32'd0);
    chk("rstacc_rdata", m1_rdata, 32'h0);
    chk("rstacc_busy", busy, 32'd0);
    tick(); @(negedge clk); chk("rstacc_ack2", m1_ack, 32'd0);
    tick(); @(negedge clk); chk("rstacc_ack3", m1_ack, 32'd0);
    tick();

    // reset during the access cycle of a store: the write still lands
    drive(1'b0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    chk("rststore_ack", m0_ack, 32'd0);
    chk("rststore_busy", busy, 32'd0);
    tick();
    xact(1'b0, 1'b0, 32'h20, 4'hF, 32'h0, rd);
    chk("rststore_load", rd, 32'h12345678);

    // round-robin contention with both requests held from reset
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h44, 4'hF, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      @(negedge clk);
      c = k + 1;
      chk("rr_ack0", m0_ack, (c == 2 || c == 8) ? 32'd1 : 32'd0);
      chk("rr_ack1", m1_ack, (c == 5 || c == 11) ? 32'd1 : 32'd0);
      chk("rr_busy", busy, (c == 3 || c == 6 || c == 9) ? 32'd0 : 32'd1);
    end
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    chk("rr_rdata0", m0_rdata, 32'hDEADAAEF);
    chk("rr_rdata1", m1_rdata, 32'h11000044);
    tick(); tick();

    // fixed priority: port 1 starves until port 0 lets go
    n0_req = 1'b1; n1_req = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      @(negedge clk);
      c = k + 1;
      chk("fp_ack0", n0_ack, (c == 2 || c == 5 || c == 8 || c == 11) ? 32'd1 : 32'd0);
      chk("fp_ack1", n1_ack, 32'd0);
    end
    chk("fp_rdata0", n0_rdata, 32'h5A5A0001);
    tick();
    n0_req = 1'b0;
    @(negedge clk); chk("fp_ack1_c12", n1_ack, 32'd0);
    tick(); @(negedge clk); chk("fp_ack1_c13", n1_ack, 32'd0);
    tick(); @(negedge clk); chk("fp_ack1_c14", n1_ack, 32'd1);
    chk("fp_ack0_c14", n0_ack, 32'd0);
    tick();
    n1_req = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
